// File: rtl/pwm_servo_capture.sv
// pwm_servo_capture: measures the high width and rise-to-rise period of a servo
// PWM input in prescaled ticks, qualifies each frame and reports the position.
module pwm_servo_capture #(
  parameter int unsigned TICK_MAX   = 269,
  parameter int unsigned WIDTH_MIN  = 50,
  parameter int unsigned WIDTH_MAX  = 250,
  parameter int unsigned PERIOD_MIN = 1800,
  parameter int unsigned PERIOD_MAX = 2200,
  parameter int unsigned TIMEOUT    = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_in,
  output logic [15:0] width,
  output logic [15:0] period,
  output logic        valid,
  output logic        lock,
  output logic        err,
  output logic [7:0]  led
);

  localparam int TW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);

  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_MAX);
  localparam logic [15:0]   WIDTH_MIN_16  = 16'(WIDTH_MIN);
  localparam logic [15:0]   WIDTH_MAX_16  = 16'(WIDTH_MAX);
  localparam logic [15:0]   PERIOD_MIN_16 = 16'(PERIOD_MIN);
  localparam logic [15:0]   PERIOD_MAX_16 = 16'(PERIOD_MAX);
  localparam logic [15:0]   TIMEOUT_16    = 16'(TIMEOUT);

  localparam logic [1:0] ST_SYNC      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync3_q, sync3_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [1:0]    prime_q, prime_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   w_cnt_q, w_cnt_d;
  logic [15:0]   p_cnt_q, p_cnt_d;
  logic [15:0]   w_cap_q, w_cap_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   width_q, width_d;
  logic [15:0]   period_q, period_d;
  logic          valid_q, valid_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;

  logic          tick;
  logic [15:0]   w_inc;
  logic [15:0]   p_inc;
  logic          frame_ok;

  // prime_q keeps SYNC from trusting the synchronizer until it holds real input samples
  always_comb begin
    sync1_d = pulse_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
    fall_d  = ~sync2_q & sync3_q;
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    if (rise_q || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // The tick landing in the edge cycle is included, giving floor(cycles / tick period)
  assign w_inc = (tick && (w_cnt_q != 16'hFFFF)) ? w_cnt_q + 16'd1 : w_cnt_q;
  assign p_inc = (tick && (p_cnt_q != 16'hFFFF)) ? p_cnt_q + 16'd1 : p_cnt_q;

  assign frame_ok = (w_cap_q >= WIDTH_MIN_16) && (w_cap_q <= WIDTH_MAX_16) &&
                    (p_inc >= PERIOD_MIN_16) && (p_inc <= PERIOD_MAX_16);

  always_comb begin
    state_d  = state_q;
    w_cnt_d  = w_cnt_q;
    p_cnt_d  = p_cnt_q;
    w_cap_d  = w_cap_q;
    width_d  = width_q;
    period_d = period_q;
    lock_d   = lock_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if ((prime_q == 2'd3) && !sync2_q) begin
          state_d = ST_WAIT_RISE;
        end
      end

      ST_WAIT_RISE: begin
        if (rise_q) begin
          w_cnt_d = '0;
          p_cnt_d = '0;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        w_cnt_d = w_inc;
        p_cnt_d = p_inc;
        if (fall_q) begin
          w_cap_d = w_inc;
          state_d = ST_LOW;
        end
        if (p_inc >= TIMEOUT_16) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = ST_SYNC;
        end
      end

      ST_LOW: begin
        p_cnt_d = p_inc;
        if (rise_q) begin
          if (frame_ok) begin
            width_d  = w_cap_q;
            period_d = p_inc;
            valid_d  = 1'b1;
            lock_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
            lock_d = 1'b0;
          end
          w_cnt_d = '0;
          p_cnt_d = '0;
          state_d = ST_HIGH;
        end else if (p_inc >= TIMEOUT_16) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = ST_SYNC;
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      prime_q    <= 2'd0;
      tick_cnt_q <= '0;
      w_cnt_q    <= '0;
      p_cnt_q    <= '0;
      w_cap_q    <= '0;
      state_q    <= ST_SYNC;
      width_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      prime_q    <= prime_d;
      tick_cnt_q <= tick_cnt_d;
      w_cnt_q    <= w_cnt_d;
      p_cnt_q    <= p_cnt_d;
      w_cap_q    <= w_cap_d;
      state_q    <= state_d;
      width_q    <= width_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  assign width  = width_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign lock   = lock_q;
  assign err    = err_q;
  assign led    = width_q[7:0];

endmodule

// File: tb/tb_pwm_servo_capture.sv
// tb_pwm_servo_capture: drives fixed, swept, boundary, timeout, reset and random
// pulse trains and checks every cycle against an event-level frame model.
module tb_pwm_servo_capture;

  localparam int TICK_MAX   = 4;
  localparam int T          = TICK_MAX + 1;
  localparam int WIDTH_MIN  = 10;
  localparam int WIDTH_MAX  = 30;
  localparam int PERIOD_MIN = 60;
  localparam int PERIOD_MAX = 80;
  localparam int TIMEOUT    = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        pulse_in;
  logic [15:0] width;
  logic [15:0] period;
  logic        valid;
  logic        lock;
  logic        err;
  logic [7:0]  led;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int vcount = 0;
  int ecount = 0;
  int last_err_edge = 0;
  int last_rise_edge = 0;

  pwm_servo_capture #(
    .TICK_MAX(TICK_MAX), .WIDTH_MIN(WIDTH_MIN), .WIDTH_MAX(WIDTH_MAX),
    .PERIOD_MIN(PERIOD_MIN), .PERIOD_MAX(PERIOD_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .width(width), .period(period), .valid(valid),
    .lock(lock), .err(err), .led(led)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_ARMED, M_MEAS} mode_t;
  typedef struct {int at; bit tmo; int w; int p;} ev_t;

  ev_t         evq[$];
  mode_t       mode;
  int          arm_from;
  int          rise_t;
  int          fall_t;
  bit          pv;
  logic [15:0] m_width;
  logic [15:0] m_period;
  logic        m_valid;
  logic        m_lock;
  logic        m_err;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic applyStimulus(input int h, input int l);
    pulse_in = 1'b1;
    last_rise_edge = edge_n + 1;
    repeat (h) @(negedge clk);
    pulse_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Raw edges are handled as seen at the pin; frame results land 3 edges later
  always @(posedge clk) begin : model_proc
    ev_t ev;
    edge_n++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_width  = '0;
      m_period = '0;
      m_lock   = 1'b0;
      mode     = M_IDLE;
      arm_from = edge_n + 2;
      pv       = 1'b0;
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].at == edge_n) begin
        ev = evq.pop_front();
        if (!ev.tmo && ev.w >= WIDTH_MIN && ev.w <= WIDTH_MAX &&
            ev.p >= PERIOD_MIN && ev.p <= PERIOD_MAX) begin
          m_width  = 16'(ev.w);
          m_period = 16'(ev.p);
          m_valid  = 1'b1;
          m_lock   = 1'b1;
        end else begin
          m_err  = 1'b1;
          m_lock = 1'b0;
        end
      end
      if (pulse_in && !pv) begin
        if (mode == M_MEAS) begin
          ev.at  = edge_n + 3;
          ev.tmo = 1'b0;
          ev.w   = (fall_t - rise_t) / T;
          ev.p   = (edge_n - rise_t) / T;
          evq.push_back(ev);
        end
        if (mode != M_IDLE) begin
          mode   = M_MEAS;
          rise_t = edge_n;
        end
      end else begin
        if (!pulse_in && pv && mode == M_MEAS) fall_t = edge_n;
        if (mode == M_MEAS && edge_n - rise_t == TIMEOUT * T) begin
          ev.at  = edge_n + 3;
          ev.tmo = 1'b1;
          ev.w   = 0;
          ev.p   = 0;
          evq.push_back(ev);
          mode     = M_IDLE;
          arm_from = edge_n + 2;
        end
      end
      if (!pulse_in && mode == M_IDLE && edge_n >= arm_from) mode = M_ARMED;
      pv = pulse_in;
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (edge_n > 0) begin
      checkOutput("outputs", {width, period, valid, lock, err, led},
                  {m_width, m_period, m_valid, m_lock, m_err, m_width[7:0]});
      if (valid === 1'b1) vcount++;
      if (err === 1'b1) begin
        ecount++;
        last_err_edge = edge_n;
      end
    end
  end

  initial begin
    int vc0;
    int ec0;
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_width", 64'(width), 64'd0);
    checkOutput("reset_lock", 64'(lock), 64'd0);
    repeat (20) @(negedge clk);

    repeat (3) applyStimulus(100, 250);
    checkOutput("nominal_width", 64'(width), 64'd20);
    checkOutput("nominal_period", 64'(period), 64'd70);
    checkOutput("nominal_led", 64'(led), 64'd20);
    checkOutput("nominal_lock", 64'(lock), 64'd1);
    checkOutput("nominal_valid_count", 64'(vcount), 64'd2);
    checkOutput("model_width", 64'(m_width), 64'd20);

    for (int t = 10; t <= 30; t++) applyStimulus(5 * t + ((t % 4 == 0) ? 4 : 0), 350 - 5 * t);
    applyStimulus(89, 261);
    applyStimulus(100, 250);
    checkOutput("floor_width", 64'(width), 64'd17);

    applyStimulus(50, 300);
    applyStimulus(100, 250);
    checkOutput("width_min_ok", 64'(width), 64'd10);
    applyStimulus(150, 200);
    applyStimulus(100, 250);
    checkOutput("width_max_ok", 64'(width), 64'd30);

    ec0 = ecount;
    applyStimulus(49, 301);
    applyStimulus(100, 250);
    checkOutput("width_49_lock", 64'(lock), 64'd0);
    checkOutput("width_49_hold", 64'(width), 64'd20);
    checkOutput("width_49_err", 64'(ecount - ec0), 64'd1);
    applyStimulus(155, 195);
    applyStimulus(100, 250);
    checkOutput("width_251_lock", 64'(lock), 64'd0);
    applyStimulus(100, 199);
    applyStimulus(100, 250);
    checkOutput("period_1799_lock", 64'(lock), 64'd0);
    checkOutput("period_1799_hold", 64'(period), 64'd70);
    applyStimulus(100, 305);
    applyStimulus(100, 250);
    checkOutput("period_2201_lock", 64'(lock), 64'd0);
    applyStimulus(100, 200);
    applyStimulus(100, 304);
    checkOutput("period_min_ok", 64'(period), 64'd60);
    applyStimulus(100, 250);
    checkOutput("period_max_ok", 64'(period), 64'd80);

    applyStimulus(100, 700);
    checkOutput("timeout_lock", 64'(lock), 64'd0);
    checkOutput("timeout_delay", 64'(last_err_edge - last_rise_edge), 64'd603);
    vc0 = vcount;
    applyStimulus(100, 250);
    applyStimulus(100, 250);
    checkOutput("resume_valid", 64'(vcount - vc0), 64'd1);

    applyStimulus(800, 200);
    checkOutput("stuck_high_lock", 64'(lock), 64'd0);
    vc0 = vcount;
    applyStimulus(100, 250);
    applyStimulus(100, 250);
    checkOutput("stuck_high_resume", 64'(vcount - vc0), 64'd1);

    applyStimulus(100, 250);
    pulse_in = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_width", 64'(width), 64'd0);
    checkOutput("midreset_period", 64'(period), 64'd0);
    checkOutput("midreset_lock", 64'(lock), 64'd0);
    repeat (60) @(negedge clk);
    pulse_in = 1'b0;
    repeat (250) @(negedge clk);
    vc0 = vcount;
    applyStimulus(100, 250);
    applyStimulus(100, 250);
    checkOutput("midreset_resume", 64'(vcount - vc0), 64'd1);

    for (int i = 0; i < 40; i++) begin
      int h;
      int p;
      h = int'($urandom_range(160, 40));
      p = int'($urandom_range(410, 290));
      applyStimulus(h, p - h);
    end
    applyStimulus(100, 250);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
